// File: rtl/prescaled_timer_pkg.sv
// Shared definitions for the prescaled timer.
//   timer_state_e : controller states (IDLE, RUN, EXPIRED)
//   can_start()   : true in the states where a start pulse is accepted
package prescaled_timer_pkg;

  localparam int unsigned DEFAULT_WIDTH       = 16;
  localparam int unsigned DEFAULT_PRESC_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } timer_state_e;

  function automatic logic can_start(input timer_state_e st);
    return (st != RUN);
  endfunction

endpackage

// File: rtl/prescaled_timer_delta_counter.sv
// delta_counter: loadable up/down counter that adds or subtracts delta_i per
// enabled cycle. One extra bit above WIDTH holds the carry/borrow of the last
// update and is exposed as overflow_o.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : synchronous clear (highest priority)
//   load_i, d_i   : synchronous load of d_i (clears the overflow bit)
//   en_i, down_i  : apply delta_i, downwards when down_i is set
//   delta_i       : step size
//   q_o           : low WIDTH bits of the counter
//   overflow_o    : carry/borrow bit of the counter
module delta_counter #(
  parameter int unsigned WIDTH           = 4,
  parameter bit          STICKY_OVERFLOW = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] delta_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o,
  output logic             overflow_o
);

  logic [WIDTH:0] counter_q, counter_d;
  logic [WIDTH:0] base;

  // Arithmetic always starts from the in-range value, so the top bit reports
  // only the latest update unless the sticky variant keeps it.
  assign base = {1'b0, counter_q[WIDTH-1:0]};

  always_comb begin
    counter_d = counter_q;
    if (clear_i) begin
      counter_d = '0;
    end else if (load_i) begin
      counter_d = {1'b0, d_i};
    end else begin
      if (en_i) begin
        counter_d = down_i ? (base - {1'b0, delta_i}) : (base + {1'b0, delta_i});
      end
      if (STICKY_OVERFLOW && counter_q[WIDTH]) begin
        counter_d[WIDTH] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      counter_q <= '0;
    end else begin
      counter_q <= counter_d;
    end
  end

  assign q_o        = counter_q[WIDTH-1:0];
  assign overflow_o = counter_q[WIDTH];

endmodule

// File: rtl/prescaled_timer.sv
// prescaled_timer: programmable timer with prescaler, up/down step counting,
// compare-match expiry, one-shot or auto-reload operation, sticky interrupt
// and sticky wrap-error flags.
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   start_i, stop_i    : start (IDLE/EXPIRED only) and abort (any state, wins)
//   periodic_i, down_i : auto-reload and count direction, captured at start
//   step_i, prescale_i : delta per tick, tick every prescale_i+1 cycles
//   reload_i, compare_i: start/reload value and expiry value
//   irq_ack_i          : clears irq_o
//   count_o            : current count
//   running_o          : high while in RUN
//   match_o            : one-cycle pulse per expiry event
//   irq_o, err_o       : sticky expiry flag, sticky wrap-error flag
module prescaled_timer
  import prescaled_timer_pkg::*;
#(
  parameter int unsigned WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned PRESC_WIDTH = DEFAULT_PRESC_WIDTH
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic                   stop_i,
  input  logic                   periodic_i,
  input  logic                   down_i,
  input  logic [WIDTH-1:0]       step_i,
  input  logic [PRESC_WIDTH-1:0] prescale_i,
  input  logic [WIDTH-1:0]       reload_i,
  input  logic [WIDTH-1:0]       compare_i,
  input  logic                   irq_ack_i,
  output logic [WIDTH-1:0]       count_o,
  output logic                   running_o,
  output logic                   match_o,
  output logic                   irq_o,
  output logic                   err_o
);

  timer_state_e state_q, state_d;

  logic [PRESC_WIDTH-1:0] presc_q, presc_d;

  logic                   sh_periodic_q;
  logic                   sh_down_q;
  logic [WIDTH-1:0]       sh_step_q;
  logic [PRESC_WIDTH-1:0] sh_presc_q;
  logic [WIDTH-1:0]       sh_reload_q;
  logic [WIDTH-1:0]       sh_cmp_q;

  logic irq_q;
  logic err_q;

  logic             in_run;
  logic             start_acc;
  logic             tick;
  logic             tick_live;
  logic             expiry;
  logic             cnt_load;
  logic             cnt_en;
  logic             ovf;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_ld_val;

  assign in_run    = (state_q == RUN);
  assign start_acc = can_start(state_q) && start_i && !stop_i;
  assign tick      = in_run && (presc_q == sh_presc_q);
  // A pending wrap or an abort swallows the tick so the count holds.
  assign tick_live = tick && !stop_i && !ovf;
  assign expiry    = tick_live && (cnt_q == sh_cmp_q);
  assign cnt_en    = tick_live && !expiry;
  assign cnt_load  = start_acc || (expiry && sh_periodic_q);
  // A start loads the live input; an auto-reload uses the captured value.
  assign cnt_ld_val = start_acc ? reload_i : sh_reload_q;

  delta_counter #(
    .WIDTH          (WIDTH),
    .STICKY_OVERFLOW(1'b0)
  ) u_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clear_i   (1'b0),
    .en_i      (cnt_en),
    .load_i    (cnt_load),
    .down_i    (sh_down_q),
    .delta_i   (sh_step_q),
    .d_i       (cnt_ld_val),
    .q_o       (cnt_q),
    .overflow_o(ovf)
  );

  always_comb begin
    presc_d = '0;
    if (in_run && !stop_i && !tick) begin
      presc_d = presc_q + PRESC_WIDTH'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, EXPIRED: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (start_i) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop_i) begin
          state_d = IDLE;
        end else if (ovf) begin
          state_d = EXPIRED;
        end else if (expiry && !sh_periodic_q) begin
          state_d = EXPIRED;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      presc_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_periodic_q <= 1'b0;
      sh_down_q     <= 1'b0;
      sh_step_q     <= '0;
      sh_presc_q    <= '0;
      sh_reload_q   <= '0;
      sh_cmp_q      <= '0;
    end else if (start_acc) begin
      sh_periodic_q <= periodic_i;
      sh_down_q     <= down_i;
      sh_step_q     <= step_i;
      sh_presc_q    <= prescale_i;
      sh_reload_q   <= reload_i;
      sh_cmp_q      <= compare_i;
    end
  end

  // A new expiry wins over a simultaneous acknowledge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_q <= 1'b0;
    end else if (expiry) begin
      irq_q <= 1'b1;
    end else if (irq_ack_i) begin
      irq_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (start_acc) begin
      err_q <= 1'b0;
    end else if (in_run && ovf) begin
      err_q <= 1'b1;
    end
  end

  assign count_o   = cnt_q;
  assign running_o = in_run;
  assign match_o   = expiry;
  assign irq_o     = irq_q;
  assign err_o     = err_q;

endmodule

// File: tb/tb_prescaled_timer.sv
// Testbench for prescaled_timer: table-driven periodic scenario, hand-written
// corner sequences, and a randomized run against a behavioural model.
module tb_prescaled_timer;

  localparam int W  = 16;
  localparam int PW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, stop, periodic, down, ack;
  logic [W-1:0]  step, reload, compare;
  logic [PW-1:0] prescale;
  logic [W-1:0]  count;
  logic          running, match, irq, err;

  always #5 clk = ~clk;

  prescaled_timer #(.WIDTH(W), .PRESC_WIDTH(PW)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (start),
    .stop_i    (stop),
    .periodic_i(periodic),
    .down_i    (down),
    .step_i    (step),
    .prescale_i(prescale),
    .reload_i  (reload),
    .compare_i (compare),
    .irq_ack_i (ack),
    .count_o   (count),
    .running_o (running),
    .match_o   (match),
    .irq_o     (irq),
    .err_o     (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        start, stop, ack;
    logic [15:0] cnt;
    logic        run, match, irq, err;
  } vec_t;

  function automatic vec_t mk(bit st, bit sp, bit ak, int c, bit r, bit m, bit i, bit e);
    vec_t v;
    v.start = st; v.stop = sp; v.ack = ak; v.cnt = 16'(c);
    v.run = r; v.match = m; v.irq = i; v.err = e;
    return v;
  endfunction

  task automatic cfg(input bit per, input bit dn, input int stp, input int psc,
                     input int rld, input int cmp);
    periodic = per; down = dn; step = 16'(stp); prescale = 8'(psc);
    reload = 16'(rld); compare = 16'(cmp);
  endtask

  task automatic quiet();
    start = 1'b0; stop = 1'b0; ack = 1'b0;
  endtask

  task automatic do_reset(input bit chk);
    quiet();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (chk) begin
      check("rst_count", 32'(count), 32'd0);
      check("rst_running", 32'(running), 32'd0);
      check("rst_match", 32'(match), 32'd0);
      check("rst_irq", 32'(irq), 32'd0);
      check("rst_err", 32'(err), 32'd0);
    end
    #1 rst_n = 1'b1;
  endtask

  // Issue a start pulse; returns just after the edge that enters RUN.
  task automatic pulse_start();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  // Behavioural reference: mode 0 idle, 1 counting, 2 finished.
  int m_mode, m_cnt, m_phase, m_irq, m_err, m_wrap;
  int m_per, m_down, m_step, m_presc, m_reload, m_cmp;
  int e_cnt, e_run, e_match, e_irq, e_err;

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_phase = 0; m_irq = 0; m_err = 0; m_wrap = 0;
    m_per = 0; m_down = 0; m_step = 0; m_presc = 0; m_reload = 0; m_cmp = 0;
  endtask

  task automatic model_cycle();
    int nxt;
    e_cnt = m_cnt; e_run = (m_mode == 1) ? 1 : 0; e_irq = m_irq; e_err = m_err; e_match = 0;
    if (m_mode == 1) begin
      if (stop) begin
        if (m_wrap != 0) m_err = 1;
        m_mode = 0; m_phase = 0;
      end else if (m_wrap != 0) begin
        m_err = 1; m_mode = 2; m_phase = 0;
      end else if (m_phase == m_presc) begin
        if (m_cnt == m_cmp) begin
          e_match = 1;
          if (m_per != 0) m_cnt = m_reload;
          else m_mode = 2;
        end else begin
          nxt = (m_down != 0) ? m_cnt - m_step : m_cnt + m_step;
          if (nxt < 0 || nxt > 65535) m_wrap = 1;
          m_cnt = nxt & 32'hFFFF;
        end
        m_phase = 0;
      end else begin
        m_phase = m_phase + 1;
      end
    end else if (stop) begin
      m_mode = 0;
    end else if (start) begin
      m_per = periodic; m_down = down; m_step = step; m_presc = prescale;
      m_reload = reload; m_cmp = compare;
      m_cnt = reload; m_err = 0; m_wrap = 0; m_phase = 0; m_mode = 1;
    end
    if (e_match != 0) m_irq = 1;
    else if (ack) m_irq = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[13];
  int   first, pulses;

  initial begin
    rst_n = 1'b0;
    quiet();
    cfg(0, 0, 0, 0, 0, 0);
    do_reset(1'b1);

    // Periodic down-count 10,8,6,4,10,... with ack coincident with an expiry,
    // then a stop mid-run and a simultaneous start+stop while idle.
    tbl[0]  = mk(1, 0, 0,  0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 10, 1, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0,  8, 1, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0,  6, 1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0,  4, 1, 1, 0, 0);
    tbl[5]  = mk(0, 0, 0, 10, 1, 0, 1, 0);
    tbl[6]  = mk(0, 0, 0,  8, 1, 0, 1, 0);
    tbl[7]  = mk(0, 0, 0,  6, 1, 0, 1, 0);
    tbl[8]  = mk(0, 0, 1,  4, 1, 1, 1, 0);
    tbl[9]  = mk(0, 0, 1, 10, 1, 0, 1, 0);
    tbl[10] = mk(0, 1, 0,  8, 1, 0, 0, 0);
    tbl[11] = mk(1, 1, 0,  8, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 0,  8, 0, 0, 0, 0);
    cfg(1, 1, 2, 0, 10, 4);
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      start = tbl[i].start; stop = tbl[i].stop; ack = tbl[i].ack;
      @(negedge clk);
      check($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_running", i), 32'(running), 32'(tbl[i].run));
      check($sformatf("tbl%0d_match", i), 32'(match), 32'(tbl[i].match));
      check($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
      check($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
    end

    // One-shot up-count, prescale 3: sixth tick lands 24 cycles after RUN entry.
    do_reset(1'b0);
    cfg(0, 0, 1, 3, 0, 5);
    pulse_start();
    first = -1; pulses = 0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (match) begin
        pulses++;
        if (first < 0) begin
          first = n;
          check("oneshot_count_at_match", 32'(count), 32'd5);
        end
      end
      if (n == 25) begin
        check("oneshot_running_after", 32'(running), 32'd0);
        check("oneshot_irq_after", 32'(irq), 32'd1);
        check("oneshot_count_held", 32'(count), 32'd5);
      end
    end
    check("oneshot_match_cycle", 32'(first), 32'd24);
    check("oneshot_match_pulses", 32'(pulses), 32'd1);

    // Up-count wrap: 0xFFF0 + 0x20 -> error, low bits shown, no expiry.
    do_reset(1'b0);
    cfg(0, 0, 16'h20, 0, 16'hFFF0, 16'h5);
    pulse_start();
    pulses = 0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (match) pulses++;
      if (n == 1) check("wrap_count_start", 32'(count), 32'hFFF0);
      if (n == 2) begin
        check("wrap_count_low", 32'(count), 32'h0010);
        check("wrap_err_pending", 32'(err), 32'd0);
      end
      if (n == 3) begin
        check("wrap_err", 32'(err), 32'd1);
        check("wrap_running", 32'(running), 32'd0);
        check("wrap_count_held", 32'(count), 32'h0010);
      end
    end
    check("wrap_no_match", 32'(pulses), 32'd0);
    check("wrap_no_irq", 32'(irq), 32'd0);

    // Reset while running at count 3 with match and irq both high.
    do_reset(1'b0);
    cfg(1, 0, 1, 0, 3, 3);
    pulse_start();
    @(negedge clk);
    check("rr_match_first", 32'(match), 32'd1);
    @(negedge clk);
    check("rr_count_before", 32'(count), 32'd3);
    check("rr_irq_before", 32'(irq), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_count", 32'(count), 32'd0);
    check("rr_running", 32'(running), 32'd0);
    check("rr_match", 32'(match), 32'd0);
    check("rr_irq", 32'(irq), 32'd0);
    check("rr_err", 32'(err), 32'd0);
    #1 rst_n = 1'b1;
    cfg(0, 0, 1, 0, 7, 8);
    pulse_start();
    @(negedge clk);
    check("rr_restart_count", 32'(count), 32'd7);
    check("rr_restart_running", 32'(running), 32'd1);
    check("rr_restart_nomatch", 32'(match), 32'd0);
    @(negedge clk);
    check("rr_restart_match", 32'(match), 32'd1);
    @(negedge clk);
    check("rr_restart_irq", 32'(irq), 32'd1);
    check("rr_restart_idle", 32'(running), 32'd0);

    // Randomized run against the behavioural model.
    do_reset(1'b0);
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start    = ($urandom_range(0, 5) == 0);
      stop     = ($urandom_range(0, 39) == 0);
      ack      = ($urandom_range(0, 3) == 0);
      periodic = 1'($urandom_range(0, 1));
      down     = 1'($urandom_range(0, 1));
      prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) begin
        reload = 16'(16'hFFF0 + $urandom_range(0, 15));
        step   = 16'($urandom_range(1, 40));
      end else begin
        reload = 16'($urandom_range(0, 20));
        step   = 16'($urandom_range(0, 3));
      end
      compare = 16'($urandom_range(0, 20));
      @(negedge clk);
      model_cycle();
      check("rand_count", 32'(count), 32'(e_cnt));
      check("rand_running", 32'(running), 32'(e_run));
      check("rand_match", 32'(match), 32'(e_match));
      check("rand_irq", 32'(irq), 32'(e_irq));
      check("rand_err", 32'(err), 32'(e_err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
